// File: rtl/score_recorder_pkg.sv
// Shared constants for the score recorder: summary-view song code, default widths
// and the averaging FSM state encoding.
package score_recorder_pkg;

  localparam int SCORE_W_DEF = 41;
  localparam int NUSER_DEF   = 4;
  localparam int NSONG_DEF   = 3;

  localparam logic [1:0] SONG_SUMMARY = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } rec_state_t;

endpackage

// File: rtl/seq_div3.sv
// Sequential restoring divide-by-3: one quotient bit per cycle, MSB first.
// done is high during the cycle whose clock edge retires the last quotient bit.
module seq_div3 #(
  parameter int DATA_W = 43,
  parameter int Q_W    = 41
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  output logic [Q_W-1:0]    quotient,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic [1:0]        rem;
  logic [DATA_W-1:0] work;
  logic [2:0]        trial;
  logic              qbit;
  logic [1:0]        rem_next;

  // The remainder stays below 3, so the trial value never exceeds 5.
  always_comb begin
    trial    = {rem, work[DATA_W-1]};
    qbit     = (trial >= 3'd3);
    rem_next = qbit ? 2'(trial - 3'd3) : trial[1:0];
  end

  assign done     = busy && (cnt == CNT_W'(1));
  assign quotient = work[Q_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(DATA_W);
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (start) begin
      work <= dividend;
      rem  <= 2'd0;
    end else if (busy) begin
      work <= {work[DATA_W-2:0], qbit};
      rem  <= rem_next;
    end
  end

endmodule

// File: rtl/score_recorder.sv
// Per-user, per-song score register file with a sequentially computed
// three-song average for the currently selected user.
module score_recorder
  import score_recorder_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int NUSER   = NUSER_DEF,
  parameter int NSONG   = NSONG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               finished,
  input  logic [SCORE_W-1:0] score,
  input  logic [1:0]         user,
  input  logic [1:0]         song_num,
  input  logic               clear,
  output logic [SCORE_W-1:0] rec_score,
  output logic [SCORE_W-1:0] avg_score,
  output logic               avg_valid,
  output logic               wr_done
);

  localparam int SUM_W = SCORE_W + 2;

  logic [SCORE_W-1:0] rec [NUSER][NSONG];
  logic               fin_q;
  logic [1:0]         user_q;
  logic [1:0]         user_lat;
  logic               pending;
  logic               wr_ev;
  logic               trig;
  rec_state_t         state;
  logic [SUM_W-1:0]   sum_val;
  logic               div_start;
  logic [SCORE_W-1:0] div_quot;
  logic               div_done;

  // Zero-extended three-term add; three full-scale scores still fit in SUM_W bits.
  function automatic logic [SUM_W-1:0] sum3(input logic [SCORE_W-1:0] a,
                                            input logic [SCORE_W-1:0] b,
                                            input logic [SCORE_W-1:0] c);
    return SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
  endfunction

  assign wr_ev     = finished & ~fin_q & (song_num != SONG_SUMMARY);
  assign trig      = wr_ev | clear | (user != user_q);
  assign sum_val   = sum3(rec[user_lat][0], rec[user_lat][1], rec[user_lat][2]);
  assign div_start = (state == ST_SUM);

  always_comb begin
    rec_score = '0;
    if (song_num != SONG_SUMMARY) rec_score = rec[user][song_num];
  end

  // Record file, edge detect and write acknowledge; clear takes priority over a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUSER; u++)
        for (int s = 0; s < NSONG; s++)
          rec[u][s] <= '0;
      fin_q   <= 1'b0;
      user_q  <= 2'd0;
      wr_done <= 1'b0;
    end else begin
      fin_q   <= finished;
      user_q  <= user;
      wr_done <= wr_ev & ~clear;
      if (clear) begin
        for (int u = 0; u < NUSER; u++)
          for (int s = 0; s < NSONG; s++)
            rec[u][s] <= '0;
      end else if (wr_ev) begin
        rec[user][song_num] <= score;
      end
    end
  end

  // Averaging FSM: triggers arriving mid-computation are folded into one rerun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      avg_score <= '0;
      avg_valid <= 1'b1;
      pending   <= 1'b0;
      user_lat  <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            avg_valid <= 1'b0;
            user_lat  <= user;
            state     <= ST_SUM;
          end
        end
        ST_SUM: begin
          if (trig) pending <= 1'b1;
          state <= ST_DIV;
        end
        ST_DIV: begin
          if (trig) pending <= 1'b1;
          if (div_done) state <= ST_DONE;
        end
        ST_DONE: begin
          avg_score <= div_quot;
          if (!pending && !trig && (user_lat == user)) begin
            avg_valid <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            pending  <= 1'b0;
            user_lat <= user;
            state    <= ST_SUM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  seq_div3 #(
    .DATA_W (SUM_W),
    .Q_W    (SCORE_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sum_val),
    .quotient (div_quot),
    .done     (div_done)
  );

endmodule

// File: tb/tb_score_recorder.sv
// Scoreboard bench for score_recorder: expected record and average values are
// queued as stimulus is applied and compared when wr_done / avg_valid fire.
module tb_score_recorder;

  localparam int SW = 41;

  logic          clk;
  logic          rst;
  logic          finished;
  logic [SW-1:0] score;
  logic [1:0]    user;
  logic [1:0]    song_num;
  logic          clear;
  logic [SW-1:0] rec_score;
  logic [SW-1:0] avg_score;
  logic          avg_valid;
  logic          wr_done;

  score_recorder dut (
    .clk       (clk),
    .rst       (rst),
    .finished  (finished),
    .score     (score),
    .user      (user),
    .song_num  (song_num),
    .clear     (clear),
    .rec_score (rec_score),
    .avg_score (avg_score),
    .avg_valid (avg_valid),
    .wr_done   (wr_done)
  );

  int            n_chk  = 0;
  int            n_pass = 0;
  int            cyc    = 0;
  int            wr_cnt = 0;
  logic          mon_en = 1'b0;
  logic          prev_valid = 1'b0;
  logic [SW-1:0] model_rec [4][3];
  logic [63:0]   wr_q  [$];
  logic [63:0]   avg_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_avg(input int u);
    return (64'(model_rec[u][0]) + 64'(model_rec[u][1]) + 64'(model_rec[u][2])) / 3;
  endfunction

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (!rst && wr_done) begin
      wr_cnt++;
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else chk("wr_rec", rec_score, wr_q.pop_front());
    end
    if (!rst && mon_en && avg_valid && !prev_valid) begin
      if (avg_q.size() == 0) chk("avg_unexpected", 1, 0);
      else chk("avg", avg_score, avg_q.pop_front());
    end
    prev_valid = avg_valid;
  end

  task automatic wait_valid(input string tag, output int at);
    int n;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (!avg_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!avg_valid) chk({tag, "_timeout"}, 0, 1);
    at = cyc;
  endtask

  task automatic settle(input logic [1:0] u, input logic [1:0] s);
    int at;
    mon_en   = 1'b0;
    user     = u;
    song_num = s;
    wait_valid("settle", at);
    mon_en = 1'b1;
  endtask

  task automatic do_write(input logic [1:0] s, input logic [SW-1:0] v);
    int at;
    model_rec[user][s] = v;
    wr_q.push_back(64'(v));
    avg_q.push_back(exp_avg(int'(user)));
    song_num = s;
    score    = v;
    finished = 1'b1;
    repeat (3) @(posedge clk);
    #1 finished = 1'b0;
    wait_valid("do_write", at);
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, at, w0;
    rst = 1'b1; finished = 1'b0; score = '0; user = 2'd0; song_num = 2'd0; clear = 1'b0;
    for (int u = 0; u < 4; u++)
      for (int s = 0; s < 3; s++)
        model_rec[u][s] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state
    @(negedge clk);
    chk("t1_rec", rec_score, 0);
    chk("t1_avg", avg_score, 0);
    chk("t1_valid", avg_valid, 1);
    chk("t1_wr_done", wr_done, 0);
    for (int u = 0; u < 4; u++)
      for (int s = 0; s < 4; s++) begin
        user = 2'(u); song_num = 2'(s);
        @(negedge clk);
        chk("t1_rec_all", rec_score, 0);
      end
    settle(2'd1, 2'd0);

    // 2: single write, held finished, latency
    model_rec[1][0] = 90;
    wr_q.push_back(90);
    avg_q.push_back(30);
    w0 = wr_cnt;
    score = 90; finished = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    chk("t2_rec", rec_score, 90);
    repeat (9) @(posedge clk);
    #1 finished = 1'b0;
    wait_valid("t2", at);
    chk("t2_latency", at - t0, 45);
    chk("t2_avg", avg_score, 30);
    chk("t2_wr_once", wr_cnt - w0, 1);
    repeat (10) @(posedge clk);
    #1;

    // 3: three songs, then overwrite song 2
    do_write(2'd1, 91);
    do_write(2'd2, 92);
    chk("t3_avg91", avg_score, 91);
    do_write(2'd2, 100);
    chk("t3_avg93", avg_score, 93);

    // 5: user change mid-computation
    model_rec[1][0] = 93;
    wr_q.push_back(93);
    song_num = 2'd0; score = 93; finished = 1'b1;
    @(posedge clk);
    #1 finished = 1'b0;
    repeat (10) @(posedge clk);
    #1 user = 2'd2;
    avg_q.push_back(exp_avg(2));
    wait_valid("t5a", at);
    chk("t5_avg_user2", avg_score, 0);
    user = 2'd1;
    avg_q.push_back(exp_avg(1));
    wait_valid("t5b", at);
    chk("t5_avg_user1", avg_score, 94);

    // 4: second write during computation forces a rerun
    settle(2'd2, 2'd0);
    model_rec[2][0] = 30;
    wr_q.push_back(30);
    score = 30; finished = 1'b1;
    @(posedge clk);
    #1 t0 = cyc; finished = 1'b0;
    repeat (9) @(posedge clk);
    #1 song_num = 2'd1; score = 60; finished = 1'b1;
    model_rec[2][1] = 60;
    wr_q.push_back(60);
    avg_q.push_back(exp_avg(2));
    @(posedge clk);
    #1 finished = 1'b0;
    wait_valid("t4", at);
    chk("t4_latency", at - t0, 90);
    chk("t4_avg", avg_score, 30);

    // 6: summary-view edge is ignored
    settle(2'd1, 2'd3);
    chk("t6_summary_rec", rec_score, 0);
    w0 = wr_cnt;
    score = 55; finished = 1'b1;
    repeat (3) @(posedge clk);
    #1 finished = 1'b0;
    @(negedge clk);
    chk("t6_no_trig", avg_valid, 1);
    chk("t6_no_wr", wr_cnt - w0, 0);
    for (int s = 0; s < 3; s++) begin
      song_num = 2'(s);
      @(negedge clk);
      chk("t6_rec_keep", rec_score, 64'(model_rec[1][s]));
    end

    // clear together with a write event
    song_num = 2'd0; score = 55; finished = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; finished = 1'b0;
    for (int u = 0; u < 4; u++)
      for (int s = 0; s < 3; s++)
        model_rec[u][s] = '0;
    avg_q.push_back(0);
    wait_valid("t6_clr", at);
    chk("t6_clr_no_wr", wr_cnt - w0, 0);
    chk("t6_clr_avg", avg_score, 0);
    for (int s = 0; s < 3; s++) begin
      song_num = 2'(s);
      @(negedge clk);
      chk("t6_clr_rec", rec_score, 0);
    end

    // async reset during DIV
    settle(2'd1, 2'd0);
    do_write(2'd0, 99);
    model_rec[1][0] = 77;
    wr_q.push_back(77);
    score = 77; finished = 1'b1;
    @(posedge clk);
    #1 finished = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_busy", avg_valid, 0);
    chk("t6_hold_avg", avg_score, 33);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", avg_valid, 1);
    chk("t6_rst_avg", avg_score, 0);
    chk("t6_rst_wr_done", wr_done, 0);
    chk("t6_rst_rec", rec_score, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    chk("wr_q_empty", wr_q.size(), 0);
    chk("avg_q_empty", avg_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
